// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock FIFO with count-based flags, sticky errors and optional FIFO_STATS_EN statistics
module fifo_buffer #(
  parameter int DEPTH        = 8,
  parameter int WIDTH        = 64,
  parameter int AF_LEVEL     = DEPTH - 2,
  parameter int AE_LEVEL     = 2,
  parameter int SAMPLE_CYCLE = 8,
  parameter int CW           = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             produce,
  input  logic             consume,
  input  logic             clr_err,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  output logic [CW-1:0]    peak_count,
  output logic [CW-1:0]    sample_count,
  output logic             sample_valid
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic wr_ok, rd_ok;
  assign full         = count == CW'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = int'(count) >= AF_LEVEL;
  assign almost_empty = int'(count) <= AE_LEVEL;
  // a write into a full FIFO is allowed only when a read frees a slot in the same cycle
  assign wr_ok = produce & (~full | consume);
  assign rd_ok = consume & ~empty;
  // storage is deliberately left unreset
  always_ff @(posedge clk)
    if (wr_ok) mem[tail] <= in;
  // pointers, occupancy, registered read port and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) tail <= tail == PW'(DEPTH - 1) ? '0 : tail + 1'b1;
      if (rd_ok) begin
        head <= head == PW'(DEPTH - 1) ? '0 : head + 1'b1;
        out  <= mem[head];
      end
      out_valid <= rd_ok;
      count     <= count + CW'(wr_ok) - CW'(rd_ok);
      overflow  <= (overflow & ~clr_err) | (produce & full & ~consume);
      underflow <= (underflow & ~clr_err) | (consume & empty);
    end
  end
`ifdef FIFO_STATS_EN
  localparam int SW = SAMPLE_CYCLE > 1 ? $clog2(SAMPLE_CYCLE) : 1;
  logic [SW-1:0] phase;
  logic last;
  assign last = phase == SW'(SAMPLE_CYCLE - 1);
  // running peak (restarted from the current count by clr_err) and periodic occupancy samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= '0;
      peak_count   <= '0;
      sample_count <= '0;
      sample_valid <= 1'b0;
    end else begin
      peak_count   <= (clr_err || count > peak_count) ? count : peak_count;
      phase        <= last ? '0 : phase + 1'b1;
      sample_valid <= last;
      if (last) sample_count <= count;
    end
  end
`ifdef SIM
  // log each sample as "count DEPTH"
  always @(posedge clk)
    if (sample_valid) $display("%0d %0d", sample_count, DEPTH);
`endif
`else
  assign peak_count   = '0;
  assign sample_count = '0;
  assign sample_valid = 1'b0;
`endif
endmodule
